// File: rtl/raster_pixel_ctrl.sv
// raster_pixel_ctrl: per-pixel depth-test/write sequencer.
// Accepts fragments over valid/ready and issues the depth-buffer read.
// Aligns the returned Z with the fragment's Z, colour and address.
// Drives the z-test stage inputs and runs full-buffer clear sweeps.
// Optional feature macro: RASTER_CTRL_STATS_EN adds the stat_accepted and
// stat_written counters and their output ports.
module raster_pixel_ctrl #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned NUM_PIXELS = 307200,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [ADDR_W-1:0] px_addr,
  input  logic [17:0]       px_z,
  input  logic [15:0]       px_color,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              zb_rden,
  output logic [ADDR_W-1:0] zb_raddr,
  input  logic [17:0]       zb_rdata,
  output logic [17:0]       re_pixelZ,
  output logic [17:0]       re_currZ,
  output logic [15:0]       re_color,
  output logic              re_raster,
  output logic              re_clear,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              re_wren
`ifdef RASTER_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_accepted,
  output logic [31:0]       stat_written
`endif
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SWEEP,
    ST_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_clear;

  // Fragment pipeline: stage 0 is the cycle after accept, the last stage is
  // the output (write) cycle, aligned with zb_rdata.
  logic [RD_LAT-1:0] r_vld;
  logic [ADDR_W-1:0] r_addr_p [RD_LAT];
  logic [17:0]       r_z_p    [RD_LAT];
  logic [15:0]       r_col_p  [RD_LAT];

  logic              w_hazard;
  logic              w_inflight;
  logic              w_accept;
  logic              w_out_vld;

  // Read-after-write hazard: block a fragment whose address is still in
  // flight, including the write cycle itself, so its read sees the new Z.
  always_comb begin
    w_hazard = 1'b0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      if (r_vld[i] && (r_addr_p[i] == px_addr)) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign w_inflight = |r_vld;
  assign w_out_vld  = r_vld[RD_LAT-1];

  // A clear request in RUN takes priority over a simultaneous fragment.
  assign px_ready = (r_state == ST_RUN) && !clear_req && !w_hazard;
  assign w_accept = px_valid && px_ready;

  assign zb_rden   = w_accept;
  assign zb_raddr  = w_accept ? px_addr : '0;

  assign re_raster  = w_out_vld;
  assign re_clear   = r_clear;
  assign re_pixelZ  = w_out_vld ? r_z_p[RD_LAT-1]   : '0;
  assign re_color   = w_out_vld ? r_col_p[RD_LAT-1] : '0;
  assign re_currZ   = w_out_vld ? zb_rdata          : '0;
  assign wr_addr    = r_clear   ? r_cnt :
                      (w_out_vld ? r_addr_p[RD_LAT-1] : '0);
  assign clear_busy = r_busy;
  assign clear_done = r_done;

  // Fragment shift pipeline, RD_LAT stages deep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_addr_p[i] <= '0;
        r_z_p[i]    <= '0;
        r_col_p[i]  <= '0;
      end
    end else begin
      r_vld[0]    <= w_accept;
      r_addr_p[0] <= px_addr;
      r_z_p[0]    <= px_z;
      r_col_p[0]  <= px_color;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_vld[i]    <= r_vld[i-1];
        r_addr_p[i] <= r_addr_p[i-1];
        r_z_p[i]    <= r_z_p[i-1];
        r_col_p[i]  <= r_col_p[i-1];
      end
    end
  end

  // Control FSM with registered busy/done/clear outputs and sweep counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_done <= 1'b0;
          if (clear_req) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!w_inflight) begin
            r_state <= ST_SWEEP;
            r_clear <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_SWEEP: begin
          if (r_cnt == LP_LAST) begin
            r_state <= ST_DONE;
            r_clear <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_RUN;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_clear <= 1'b0;
        end
      endcase
    end
  end

`ifdef RASTER_CTRL_STATS_EN
  logic [31:0] r_stat_acc;
  logic [31:0] r_stat_wr;

  // Free-running statistics, untouched by the clear sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_acc <= '0;
      r_stat_wr  <= '0;
    end else begin
      if (w_accept) begin
        r_stat_acc <= r_stat_acc + 32'd1;
      end
      if (w_out_vld && re_wren) begin
        r_stat_wr <= r_stat_wr + 32'd1;
      end
    end
  end

  assign stat_accepted = r_stat_acc;
  assign stat_written  = r_stat_wr;
`else
  logic w_unused_wren;
  assign w_unused_wren = re_wren;
`endif

endmodule

// File: tb/tb_raster_pixel_ctrl.sv
// Bench for raster_pixel_ctrl: cycle-level reference model plus directed
// scenarios with hand-computed expectations.
module tb_raster_pixel_ctrl;

  localparam int ADDR_W = 19;
  localparam int NPIX   = 1200;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              px_valid;
  logic              px_ready;
  logic [ADDR_W-1:0] px_addr;
  logic [17:0]       px_z;
  logic [15:0]       px_color;
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;
  logic              zb_rden;
  logic [ADDR_W-1:0] zb_raddr;
  logic [17:0]       zb_rdata;
  logic [17:0]       re_pixelZ;
  logic [17:0]       re_currZ;
  logic [15:0]       re_color;
  logic              re_raster;
  logic              re_clear;
  logic [ADDR_W-1:0] wr_addr;
  logic              re_wren;
`ifdef RASTER_CTRL_STATS_EN
  logic [31:0]       stat_accepted;
  logic [31:0]       stat_written;
`endif

  raster_pixel_ctrl #(
    .ADDR_W    (ADDR_W),
    .NUM_PIXELS(NPIX),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_addr   (px_addr),
    .px_z      (px_z),
    .px_color  (px_color),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .zb_rden   (zb_rden),
    .zb_raddr  (zb_raddr),
    .zb_rdata  (zb_rdata),
    .re_pixelZ (re_pixelZ),
    .re_currZ  (re_currZ),
    .re_color  (re_color),
    .re_raster (re_raster),
    .re_clear  (re_clear),
    .wr_addr   (wr_addr),
    .re_wren   (re_wren)
`ifdef RASTER_CTRL_STATS_EN
    ,
    .stat_accepted(stat_accepted),
    .stat_written (stat_written)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Depth memory environment: registered read, RD_LAT cycles of latency.
  logic [17:0] mem     [0:2047];
  logic [17:0] rd_pipe [0:RD_LAT-1];

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
  end

  always @(posedge clk) begin
    rd_pipe[0] <= zb_rden ? mem[zb_raddr[10:0]] : 18'd0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (re_raster && re_wren) mem[wr_addr[10:0]] <= re_pixelZ;
    if (re_clear) mem[wr_addr[10:0]] <= 18'd0;
  end

  assign zb_rdata = rd_pipe[RD_LAT-1];

  // Reference model: fragments in flight as a queue with output cycle,
  // mode 0 RUN / 1 DRAIN / 2 SWEEP / 3 DONE, expected Z memory.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [17:0]       z;
    logic [15:0]       col;
    logic [17:0]       cz;
    int                out;
  } frag_t;

  frag_t             q[$];
  logic [17:0]       em [0:2047];
  int                mode = 0;
  int                sweep_start = 0;
  int                m_acc = 0;
  int                m_wr  = 0;
  bit                e_rdy, e_acc, e_ras, e_clr, was_empty;
  logic [ADDR_W-1:0] e_wa;
  frag_t             nf;

  initial for (int i = 0; i < 2048; i++) em[i] = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst px_ready", px_ready, 1);
      chk("rst zb_rden", zb_rden, px_valid);
      chk("rst re_raster", re_raster, 0);
      chk("rst re_clear", re_clear, 0);
      chk("rst wr_addr", wr_addr, 0);
      chk("rst clear_busy", clear_busy, 0);
      chk("rst clear_done", clear_done, 0);
      chk("rst re_pixelZ", re_pixelZ, 0);
      chk("rst re_color", re_color, 0);
`ifdef RASTER_CTRL_STATS_EN
      chk("rst stat_accepted", stat_accepted, 0);
      chk("rst stat_written", stat_written, 0);
      m_acc = 0;
      m_wr  = 0;
`endif
      q.delete();
      mode = 0;
    end else begin
      e_rdy = (mode == 0) && !clear_req;
      foreach (q[i]) if (q[i].addr == px_addr) e_rdy = 0;
      e_acc = px_valid && e_rdy;
      e_ras = (q.size() > 0) && (q[0].out == cyc);
      e_clr = (mode == 2);
      e_wa  = e_clr ? ADDR_W'(cyc - sweep_start) : (e_ras ? q[0].addr : '0);

      chk("px_ready", px_ready, e_rdy);
      chk("zb_rden", zb_rden, e_acc);
      chk("zb_raddr", zb_raddr, e_acc ? px_addr : '0);
      chk("re_raster", re_raster, e_ras);
      chk("re_clear", re_clear, e_clr);
      chk("wr_addr", wr_addr, e_wa);
      chk("re_pixelZ", re_pixelZ, e_ras ? q[0].z : 18'd0);
      chk("re_color", re_color, e_ras ? q[0].col : 16'd0);
      chk("re_currZ", re_currZ, e_ras ? q[0].cz : 18'd0);
      chk("clear_busy", clear_busy, (mode == 1) || (mode == 2));
      chk("clear_done", clear_done, mode == 3);
`ifdef RASTER_CTRL_STATS_EN
      chk("stat_accepted", stat_accepted, m_acc);
      chk("stat_written", stat_written, m_wr);
      if (e_acc) m_acc++;
      if (e_ras && re_wren) m_wr++;
`endif
      // Read snapshot precedes this cycle's write commit.
      if (e_acc) begin
        nf.addr = px_addr;
        nf.z    = px_z;
        nf.col  = px_color;
        nf.cz   = em[px_addr[10:0]];
        nf.out  = cyc + RD_LAT;
      end
      if (e_ras && re_wren) em[q[0].addr[10:0]] = q[0].z;
      if (e_clr) em[e_wa[10:0]] = '0;
      was_empty = (q.size() == 0);
      if (e_ras) void'(q.pop_front());
      if (e_acc) q.push_back(nf);
      case (mode)
        0: if (clear_req) mode = 1;
        1: if (was_empty) begin mode = 2; sweep_start = cyc + 1; end
        2: if (cyc - sweep_start == NPIX - 1) mode = 3;
        default: mode = 0;
      endcase
    end
  end

  task automatic send(input logic [ADDR_W-1:0] a, input logic [17:0] z,
                      input logic [15:0] c, output int acc_cyc);
    px_valid = 1'b1;
    px_addr  = a;
    px_z     = z;
    px_color = c;
    acc_cyc  = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (px_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept timeout addr %0d: got no px_ready expected accept", a);
    end
    @(posedge clk);
    #1;
    px_valid = 1'b0;
  endtask

  task automatic wait_done(input int pulse_at, output int nclr, output bit seen);
    nclr = 0;
    seen = 0;
    for (int k = 0; k < NPIX + 200; k++) begin
      @(posedge clk);
      #1;
      clear_req = (k == pulse_at);
      @(negedge clk);
      if (re_clear) nclr++;
      if (clear_done) begin
        seen = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    clear_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  int  t0, t1, t2, ta, tb, nclr, ndone;
  bit  seen;

  initial begin
    reset_n   = 1'b0;
    px_valid  = 1'b0;
    px_addr   = '0;
    px_z      = '0;
    px_color  = '0;
    clear_req = 1'b0;
    re_wren   = 1'b1;
    @(negedge clk);
    chk("lit reset ready", px_ready, 1);
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Back-to-back stream 10,11,12.
    send(19'd10, 18'h00A0A, 16'hC010, t0);
    send(19'd11, 18'h00B0B, 16'hC011, t1);
    send(19'd12, 18'h00C0C, 16'hC012, t2);
    chk("lit stream spacing", t2 - t0, 2);
    @(negedge clk);
    chk("lit out11 raster", re_raster, 1);
    chk("lit out11 addr", wr_addr, 11);
    chk("lit out11 z", re_pixelZ, 18'h00B0B);
    @(negedge clk);
    chk("lit out12 addr", wr_addr, 12);
    chk("lit out12 color", re_color, 16'hC012);
    idle(3);

    // Same address twice: second read waits for the first write.
    send(19'd5, 18'h00100, 16'h0505, ta);
    send(19'd5, 18'h00200, 16'h0506, tb);
    chk("lit hazard gap", tb - ta, 3);
    @(negedge clk);
    @(negedge clk);
    chk("lit hazard currZ", re_currZ, 18'h00100);
    chk("lit hazard addr", wr_addr, 5);
    idle(3);

    // Out-of-range address passes through.
    send(19'd1500, 18'h01234, 16'hBEEF, ta);
    idle(4);

    // Clear with two fragments in flight.
    send(19'd20, 18'h00020, 16'h2020, ta);
    send(19'd21, 18'h00021, 16'h2121, tb);
    clear_req = 1'b1;
    wait_done(-1, nclr, seen);
    chk("lit clear1 count", nclr, NPIX);
    chk("lit clear1 done", seen, 1);
    @(negedge clk);
    chk("lit ready after clear", px_ready, 1);
    idle(2);

    // Clear and fragment together; second request mid-sweep ignored.
    px_valid  = 1'b1;
    px_addr   = 19'd30;
    px_z      = 18'h00030;
    px_color  = 16'h3030;
    clear_req = 1'b1;
    @(negedge clk);
    chk("lit clear wins", px_ready, 0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    px_valid  = 1'b0;
    @(negedge clk);
    chk("lit busy next", clear_busy, 1);
    wait_done(100, nclr, seen);
    chk("lit clear2 count", nclr, NPIX);
    chk("lit clear2 done", seen, 1);
    idle(3);

    // Reset in the middle of a sweep.
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    seen = 0;
    for (int k = 0; k < NPIX + 50; k++) begin
      @(negedge clk);
      if (re_clear && wr_addr == 19'd1000) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("lit reached 1000", seen, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("lit midreset clear", re_clear, 0);
    chk("lit midreset busy", clear_busy, 0);
    idle(2);
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < NPIX + 20; k++) begin
      @(negedge clk);
      if (clear_done) ndone++;
    end
    chk("lit no done after reset", ndone, 0);
    chk("lit ready after reset", px_ready, 1);
    idle(1);

`ifdef RASTER_CTRL_STATS_EN
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send(19'd40, 18'h00040, 16'h4040, ta);
    send(19'd41, 18'h00041, 16'h4141, ta);
    send(19'd42, 18'h00042, 16'h4242, ta);
    send(19'd43, 18'h00043, 16'h4343, ta);
    re_wren = 1'b0;
    idle(1);
    re_wren = 1'b1;
    idle(3);
    @(negedge clk);
    chk("lit stat_accepted", stat_accepted, 4);
    chk("lit stat_written", stat_written, 3);
`endif

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
